game_controller: RTL

GAME_CONTROLLER -- requirements
Module: game_controller

---
 rtl/game_controller.sv | 216 +++++++++++++++++++++
 1 files changed

// File: rtl/game_controller.sv
// Pong-style game sequencer: serve/play/point/game-over FSM with score keeping, frame-gated by vsync.
// Optional auto-serve timer enabled by defining GAME_CONTROLLER_AUTO_SERVE_EN.
module game_controller #(
    parameter int WIN_SCORE         = 9,
    parameter int PAUSE_FRAMES      = 60,
    parameter int AUTO_SERVE_FRAMES = 120
) (
    input  logic       i_clock,
    input  logic       i_reset,
    input  logic       i_vsync_pulse,
    input  logic       i_left_serve_btn,
    input  logic       i_right_serve_btn,
    input  logic       i_left_miss,
    input  logic       i_right_miss,
    output logic       o_ball_in_game,
    output logic       o_left_player_start,
    output logic       o_right_player_start,
    output logic [3:0] o_left_score,
    output logic [3:0] o_right_score,
    output logic       o_game_over,
    output logic       o_winner
);

    // state       | meaning
    // SERVE_LEFT  | ball attached to left paddle, waiting for left press
    // SERVE_RIGHT | ball attached to right paddle, waiting for right press
    // PLAY        | ball free-running, misses scored
    // POINT       | ball held out of play for PAUSE_FRAMES vsyncs
    // GAME_OVER   | winner latched, any press restarts with loser serving
    typedef enum logic [2:0] {
        S_SERVE_LEFT,
        S_SERVE_RIGHT,
        S_PLAY,
        S_POINT,
        S_GAME_OVER
    } state_t;

    localparam int PCW = (PAUSE_FRAMES > 1) ? $clog2(PAUSE_FRAMES) : 1;
    localparam logic [PCW-1:0] PAUSE_LOAD = PCW'(PAUSE_FRAMES - 1);
    localparam logic [3:0] WIN = 4'(WIN_SCORE);

    if (WIN_SCORE < 1 || WIN_SCORE > 15 || PAUSE_FRAMES < 1 || AUTO_SERVE_FRAMES < 1) begin : g_param_check
        $error("game_controller: parameter out of range");
    end

    state_t         state_q, state_d;
    logic [3:0]     left_score_q, left_score_d;
    logic [3:0]     right_score_q, right_score_d;
    logic [PCW-1:0] pause_cnt_q, pause_cnt_d;
    logic           left_btn_q, left_btn_d;
    logic           right_btn_q, right_btn_d;
    logic           winner_q, winner_d;
    logic           server_right_q, server_right_d;
    logic           left_press, right_press;
    logic [3:0]     left_inc, right_inc;

`ifdef GAME_CONTROLLER_AUTO_SERVE_EN
    localparam int ACW = (AUTO_SERVE_FRAMES > 1) ? $clog2(AUTO_SERVE_FRAMES) : 1;
    localparam logic [ACW-1:0] AUTO_LAST = ACW'(AUTO_SERVE_FRAMES - 1);
    logic [ACW-1:0] auto_cnt_q, auto_cnt_d;
    logic           auto_fire;
`endif

    assign left_press  = i_left_serve_btn & ~left_btn_q;
    assign right_press = i_right_serve_btn & ~right_btn_q;
    assign left_inc    = left_score_q + 4'd1;
    assign right_inc   = right_score_q + 4'd1;

`ifdef GAME_CONTROLLER_AUTO_SERVE_EN
    assign auto_fire = (auto_cnt_q == AUTO_LAST);
`endif

    always_comb begin
        state_d        = state_q;
        left_score_d   = left_score_q;
        right_score_d  = right_score_q;
        pause_cnt_d    = pause_cnt_q;
        left_btn_d     = left_btn_q;
        right_btn_d    = right_btn_q;
        winner_d       = winner_q;
        server_right_d = server_right_q;
`ifdef GAME_CONTROLLER_AUTO_SERVE_EN
        auto_cnt_d     = auto_cnt_q;
`endif

        if (i_vsync_pulse) begin
            left_btn_d  = i_left_serve_btn;
            right_btn_d = i_right_serve_btn;

            case (state_q)
                S_SERVE_LEFT: begin
                    if (left_press) begin
                        state_d = S_PLAY;
                    end
`ifdef GAME_CONTROLLER_AUTO_SERVE_EN
                    else if (auto_fire) begin
                        state_d = S_PLAY;
                    end else begin
                        auto_cnt_d = auto_cnt_q + 1'b1;
                    end
`endif
                end

                S_SERVE_RIGHT: begin
                    if (right_press) begin
                        state_d = S_PLAY;
                    end
`ifdef GAME_CONTROLLER_AUTO_SERVE_EN
                    else if (auto_fire) begin
                        state_d = S_PLAY;
                    end else begin
                        auto_cnt_d = auto_cnt_q + 1'b1;
                    end
`endif
                end

                S_PLAY: begin
                    // Left wall wins ties: only the right player scores.
                    if (i_left_miss) begin
                        server_right_d = 1'b0;
                        if (right_score_q < WIN) begin
                            right_score_d = right_inc;
                        end
                        if (right_inc == WIN) begin
                            state_d  = S_GAME_OVER;
                            winner_d = 1'b1;
                        end else begin
                            state_d     = S_POINT;
                            pause_cnt_d = PAUSE_LOAD;
                        end
                    end else if (i_right_miss) begin
                        server_right_d = 1'b1;
                        if (left_score_q < WIN) begin
                            left_score_d = left_inc;
                        end
                        if (left_inc == WIN) begin
                            state_d  = S_GAME_OVER;
                            winner_d = 1'b0;
                        end else begin
                            state_d     = S_POINT;
                            pause_cnt_d = PAUSE_LOAD;
                        end
                    end
                end

                S_POINT: begin
                    if (pause_cnt_q == '0) begin
                        state_d = server_right_q ? S_SERVE_RIGHT : S_SERVE_LEFT;
                    end else begin
                        pause_cnt_d = pause_cnt_q - 1'b1;
                    end
                end

                S_GAME_OVER: begin
                    if (left_press || right_press) begin
                        left_score_d  = 4'd0;
                        right_score_d = 4'd0;
                        state_d       = winner_q ? S_SERVE_LEFT : S_SERVE_RIGHT;
                    end
                end

                default: begin
                    state_d = S_SERVE_LEFT;
                end
            endcase

`ifdef GAME_CONTROLLER_AUTO_SERVE_EN
            // Serve-to-serve never happens, so any state change restarts the serve timer.
            if (state_d != state_q) begin
                auto_cnt_d = '0;
            end
`endif
        end
    end

    always_ff @(posedge i_clock) begin
        if (i_reset) begin
            state_q              <= S_SERVE_LEFT;
            left_score_q         <= 4'd0;
            right_score_q        <= 4'd0;
            pause_cnt_q          <= '0;
            left_btn_q           <= 1'b0;
            right_btn_q          <= 1'b0;
            winner_q             <= 1'b0;
            server_right_q       <= 1'b0;
            o_left_player_start  <= 1'b1;
            o_right_player_start <= 1'b0;
            o_ball_in_game       <= 1'b0;
            o_game_over          <= 1'b0;
`ifdef GAME_CONTROLLER_AUTO_SERVE_EN
            auto_cnt_q           <= '0;
`endif
        end else begin
            state_q              <= state_d;
            left_score_q         <= left_score_d;
            right_score_q        <= right_score_d;
            pause_cnt_q          <= pause_cnt_d;
            left_btn_q           <= left_btn_d;
            right_btn_q          <= right_btn_d;
            winner_q             <= winner_d;
            server_right_q       <= server_right_d;
            o_left_player_start  <= (state_d == S_SERVE_LEFT);
            o_right_player_start <= (state_d == S_SERVE_RIGHT);
            o_ball_in_game       <= (state_d == S_PLAY);
            o_game_over          <= (state_d == S_GAME_OVER);
`ifdef GAME_CONTROLLER_AUTO_SERVE_EN
            auto_cnt_q           <= auto_cnt_d;
`endif
        end
    end

    assign o_left_score  = left_score_q;
    assign o_right_score = right_score_q;
    assign o_winner      = winner_q;

endmodule
